taillight_scheduler: RTL and testbench
======================================

Name: taillight_scheduler

Overview:
Sequencing controller for the taillight lamp datapath. It sits between the switch debouncers and the LEDG lamp outputs, driven by the single-cycle tick from the timing generator. It arbitrates left, right, hazard and brake requests into one active mode and steps the three-lamp sweep patterns. Mode changes are accepted only at sequence boundaries, so a sweep is never truncated.

Parameters:
STEP_TICKS, 1, tick pulses per pattern phase; legal range 1..15.
TICK_W, 4, width of the internal tick divider; must hold STEP_TICKS.

Ports:
CLOCK_50  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle pulse from the timing generator
left_req  in  1  debounced left-turn level
right_req  in  1  debounced right-turn level
hazard_req  in  1  debounced hazard level
brake_req  in  1  debounced brake level
left_lamps  out  3  left lamps, LEDG[7:5] order
right_lamps  out  3  right lamps, LEDG[2:0] order
mode  out  2  latched mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 BOTH
busy  out  1  high while phase != 0

Behaviour:
- Clock and reset: one clock, CLOCK_50. rst_n is asynchronous and active-low. While rst_n is low: mode=00, phase=0, divider=0, left_lamps=000, right_lamps=000, busy=0. Reset wins over a coincident tick. Reset mid-sweep blanks the lamps immediately.
- Advance pulse: the divider counts tick pulses. It issues an advance on the STEP_TICKS-th tick and then clears. With STEP_TICKS=1, advance equals tick. The divider holds at 0 while mode is IDLE and phase is 0, so the first advance is aligned to a request.
- Phase: 2-bit phase 0..3. Patterns per phase:
  - Left: 000, 001, 011, 111 (inner to outer).
  - Right: 000, 100, 110, 111.
  - 3 of 4 phases are lit, giving a 75% duty cycle.
- Mode arbitration happens only on an advance while phase==0. Priority, highest first:
  - hazard_req gives BOTH.
  - left_req and right_req together give BOTH.
  - left_req alone gives LEFT.
  - right_req alone gives RIGHT.
  - No request gives IDLE.
  If the result is not IDLE, phase goes to 1. Otherwise phase stays 0 and mode=00.
- Advance with phase in 1..3: phase increments, wrapping 3 to 0. Requests are ignored, so a dropped or newly raised request takes effect at the next boundary. Mode holds through phase 0 until the next arbitration.
- Sides: in BOTH mode both sides share the same phase, so they are always in lock-step. A side not selected by mode shows 000.
- Brake:
  - When brake_req=1 and mode is not BOTH-from-hazard, any non-flashing side shows 111 steady.
  - In IDLE, both sides show 111.
  - In hazard-derived BOTH, brake is ignored.
  - An internal flag records whether BOTH came from hazard_req.
  - Brake is not sampled at boundaries: it is re-evaluated every cycle.
- Outputs are registered. Lamps reflect a phase change or brake change one CLOCK_50 cycle after the causing edge. busy = (phase != 0), registered.
- Simultaneous events:
  - tick and a request edge in the same cycle: the request value present in that cycle is used.
  - hazard raised mid-LEFT sweep: LEFT completes to phase 0, and BOTH starts at the next advance.
- No illegal lamp patterns may appear on either side. Each side's lamp bus only makes these transitions:
  - 000 to the side's phase-1 pattern (001 left, 100 right).
  - Each phase to the next.
  - 111 to 000.
  - Any pattern to 000 on reset.
  - Steady-111 transitions are brake-caused only.

Decomposition:
- Shared include taillight_defs.vh holds:
  - mode encodings MODE_IDLE/LEFT/RIGHT/BOTH;
  - left pattern constants L_P0..L_P3;
  - right pattern constants R_P0..R_P3;
  - BRAKE_ON = 3'b111.
- One sub-module: taillight_step_div. It takes CLOCK_50, rst_n, tick, clr and produces advance, parameterised by STEP_TICKS and TICK_W.
- The arbiter, phase FSM and output pattern mux stay in taillight_scheduler.

Test Plan:
- Reset: rst_n low for 5 cycles mid-sweep, with left_lamps=011 before reset. Required: left_lamps=000, right_lamps=000, mode=00, busy=0 asynchronously, and the bench checks them while rst_n is still low.
- Left, STEP_TICKS=1: left_req=1 for 8 ticks. Required: left_lamps sequence 001, 011, 111, 000, 001, 011, 111, 000; right_lamps=000 throughout; exactly 2 activations (000 to 001).
- Drop mid-sweep: right_req=1, then right_req=0 right after the 110 phase. Required: right_lamps goes to 111 then 000, mode goes to 00 at the next advance, and no further 100 appears.
- Hazard preempt at boundary: left_req=1, hazard_req raised at phase 2. Required: left finishes at 000, then both sides show 001/100 on the same cycle and stay in lock-step for 4 phases.
- Brake: brake_req=1 with left_req=1. Required: right_lamps=111 steady while left sweeps. Adding hazard_req=1 makes both sides sweep and brake is ignored. With no requests, both sides show 111.
- Divider: STEP_TICKS=3. Required: each phase lasts exactly 3 ticks, and the first 001 appears on the 3rd tick after left_req rises.

Source files
------------

// File: rtl/taillight_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// taillight_scheduler_pkg
// Shared definitions for the taillight sequencing controller:
//   - mode_t      : latched lamp mode (IDLE / LEFT / RIGHT / BOTH)
//   - L_P0..L_P3  : left-side sweep patterns, LEDG[7:5] order
//   - R_P0..R_P3  : right-side sweep patterns, LEDG[2:0] order
//   - BRAKE_ON    : steady brake pattern, LAMPS_OFF : all dark
//   - helpers     : phase-to-pattern lookups and the request arbiter
// ---------------------------------------------------------------------------
package taillight_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_BOTH  = 2'b11
    } mode_t;

    // Left side lights inner to outer.
    localparam logic [2:0] L_P0 = 3'b000;
    localparam logic [2:0] L_P1 = 3'b001;
    localparam logic [2:0] L_P2 = 3'b011;
    localparam logic [2:0] L_P3 = 3'b111;

    // Right side is the mirror image of the left.
    localparam logic [2:0] R_P0 = 3'b000;
    localparam logic [2:0] R_P1 = 3'b100;
    localparam logic [2:0] R_P2 = 3'b110;
    localparam logic [2:0] R_P3 = 3'b111;

    localparam logic [2:0] BRAKE_ON  = 3'b111;
    localparam logic [2:0] LAMPS_OFF = 3'b000;

    function automatic logic [2:0] left_pattern(input logic [1:0] phase);
        logic [2:0] pat;
        case (phase)
            2'd0:    pat = L_P0;
            2'd1:    pat = L_P1;
            2'd2:    pat = L_P2;
            default: pat = L_P3;
        endcase
        return pat;
    endfunction

    function automatic logic [2:0] right_pattern(input logic [1:0] phase);
        logic [2:0] pat;
        case (phase)
            2'd0:    pat = R_P0;
            2'd1:    pat = R_P1;
            2'd2:    pat = R_P2;
            default: pat = R_P3;
        endcase
        return pat;
    endfunction

    // Hazard dominates, then a simultaneous left+right request, then the
    // single-side requests.
    function automatic mode_t arbitrate(input logic hazard,
                                        input logic left,
                                        input logic right);
        mode_t m;
        if (hazard)
            m = MODE_BOTH;
        else if (left && right)
            m = MODE_BOTH;
        else if (left)
            m = MODE_LEFT;
        else if (right)
            m = MODE_RIGHT;
        else
            m = MODE_IDLE;
        return m;
    endfunction

endpackage

// File: rtl/taillight_step_div.sv
// ---------------------------------------------------------------------------
// taillight_step_div
// Tick divider: issues a one-cycle advance on every STEP_TICKS-th tick.
// Ports:
//   CLOCK_50 : system clock
//   rst_n    : asynchronous active-low reset
//   tick     : one-cycle pulse from the timing generator
//   clr      : holds the count at zero (scheduler idle with no request)
//   advance  : combinational pulse, coincident with the qualifying tick
// ---------------------------------------------------------------------------
module taillight_step_div #(
    parameter int STEP_TICKS = 1,
    parameter int TICK_W     = 4
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic tick,
    input  logic clr,
    output logic advance
);

    localparam logic [TICK_W-1:0] LAST_COUNT = TICK_W'(STEP_TICKS - 1);

    logic [TICK_W-1:0] count;

    // Advance is combinational so that STEP_TICKS=1 gives advance == tick
    // with no extra latency.
    assign advance = tick && !clr && (count == LAST_COUNT);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            if (count == LAST_COUNT)
                count <= '0;
            else
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/taillight_scheduler.sv
// ---------------------------------------------------------------------------
// taillight_scheduler
// Arbitrates turn / hazard / brake requests into one lamp mode and steps the
// three-lamp sweep. Mode changes only happen at phase 0, so a sweep is never
// cut short. All outputs are registered.
// Ports:
//   CLOCK_50    : system clock, 50 MHz
//   rst_n       : asynchronous active-low reset
//   tick        : one-cycle timing pulse
//   left_req    : debounced left-turn level
//   right_req   : debounced right-turn level
//   hazard_req  : debounced hazard level
//   brake_req   : debounced brake level
//   left_lamps  : LEDG[7:5]
//   right_lamps : LEDG[2:0]
//   mode        : latched mode (00 IDLE, 01 LEFT, 10 RIGHT, 11 BOTH)
//   busy        : high while the sweep phase is non-zero
// ---------------------------------------------------------------------------
module taillight_scheduler #(
    parameter int STEP_TICKS = 1,
    parameter int TICK_W     = 4
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    input  logic       brake_req,
    output logic [2:0] left_lamps,
    output logic [2:0] right_lamps,
    output logic [1:0] mode,
    output logic       busy
);

    import taillight_scheduler_pkg::*;

    mode_t      mode_q, mode_d;
    logic [1:0] phase_q, phase_d;
    logic       hazard_q, hazard_d;
    logic [2:0] left_d, right_d;
    logic       any_req;
    logic       div_clr;
    logic       advance;

    assign any_req = left_req || right_req || hazard_req;

    // Keep the divider parked while nothing is happening so the first
    // advance is counted from the moment a request shows up.
    assign div_clr = (mode_q == MODE_IDLE) && (phase_q == 2'd0) && !any_req;

    taillight_step_div #(
        .STEP_TICKS (STEP_TICKS),
        .TICK_W     (TICK_W)
    ) u_step_div (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .tick     (tick),
        .clr      (div_clr),
        .advance  (advance)
    );

    // Next-state: arbitrate only at phase 0, otherwise just walk the sweep.
    always_comb begin
        mode_d   = mode_q;
        phase_d  = phase_q;
        hazard_d = hazard_q;
        if (advance) begin
            if (phase_q == 2'd0) begin
                mode_d   = arbitrate(hazard_req, left_req, right_req);
                hazard_d = hazard_req;
                phase_d  = (mode_d != MODE_IDLE) ? 2'd1 : 2'd0;
            end else begin
                phase_d = phase_q + 2'd1;
            end
        end
    end

    // Lamp mux works on the next state so the lamp registers change on the
    // same edge as the phase. A side that is part of the sweep always shows
    // its pattern; an unused side shows brake unless hazard owns both sides.
    always_comb begin
        logic left_sel;
        logic right_sel;
        logic brake_shown;
        left_sel    = (mode_d == MODE_LEFT)  || (mode_d == MODE_BOTH);
        right_sel   = (mode_d == MODE_RIGHT) || (mode_d == MODE_BOTH);
        brake_shown = brake_req && !((mode_d == MODE_BOTH) && hazard_d);
        if (left_sel)
            left_d = left_pattern(phase_d);
        else if (brake_shown)
            left_d = BRAKE_ON;
        else
            left_d = LAMPS_OFF;
        if (right_sel)
            right_d = right_pattern(phase_d);
        else if (brake_shown)
            right_d = BRAKE_ON;
        else
            right_d = LAMPS_OFF;
    end

    // Single state/output register bank; reset blanks the lamps at once.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_IDLE;
            phase_q     <= 2'd0;
            hazard_q    <= 1'b0;
            left_lamps  <= LAMPS_OFF;
            right_lamps <= LAMPS_OFF;
            busy        <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            hazard_q    <= hazard_d;
            left_lamps  <= left_d;
            right_lamps <= right_d;
            busy        <= (phase_d != 2'd0);
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_taillight_scheduler.sv
// ---------------------------------------------------------------------------
// tb_taillight_scheduler
// Drives two scheduler instances (STEP_TICKS=1 and STEP_TICKS=3) from the
// same stimulus. A behavioural model predicts both every cycle; directed
// sections add hand-worked lamp sequences.
// ---------------------------------------------------------------------------
module tb_taillight_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic left_req = 1'b0;
    logic right_req = 1'b0;
    logic hazard_req = 1'b0;
    logic brake_req = 1'b0;

    logic [2:0] dut1Left, dut1Right, dut3Left, dut3Right;
    logic [1:0] dut1Mode, dut3Mode;
    logic       dut1Busy, dut3Busy;

    int checks = 0;
    int failures = 0;
    int actCount = 0;
    int actStart = 0;
    int prevLeft = 0;

    // Model state per instance: index 0 is STEP_TICKS=1, index 1 is 3.
    int mCnt[2] = '{0, 0};
    int mPh[2]  = '{0, 0};
    int mMd[2]  = '{0, 0};
    int mHz[2]  = '{0, 0};
    int eLeft[2]  = '{0, 0};
    int eRight[2] = '{0, 0};
    int eMode[2]  = '{0, 0};
    int eBusy[2]  = '{0, 0};
    int stepsOf[2] = '{1, 3};

    int leftSeq[8]  = '{1, 3, 7, 0, 1, 3, 7, 0};
    int bothL[4]    = '{1, 3, 7, 0};
    int bothR[4]    = '{4, 6, 7, 0};
    int div3Seq[9]  = '{0, 0, 1, 1, 1, 3, 3, 3, 7};

    always #10 clk = ~clk;

    taillight_scheduler #(.STEP_TICKS(1), .TICK_W(4)) dut1 (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .left_req    (left_req),
        .right_req   (right_req),
        .hazard_req  (hazard_req),
        .brake_req   (brake_req),
        .left_lamps  (dut1Left),
        .right_lamps (dut1Right),
        .mode        (dut1Mode),
        .busy        (dut1Busy)
    );

    taillight_scheduler #(.STEP_TICKS(3), .TICK_W(4)) dut3 (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .left_req    (left_req),
        .right_req   (right_req),
        .hazard_req  (hazard_req),
        .brake_req   (brake_req),
        .left_lamps  (dut3Left),
        .right_lamps (dut3Right),
        .mode        (dut3Mode),
        .busy        (dut3Busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One step of the behavioural model: count ticks, pick a mode at the
    // boundary, then read lamps straight from the pattern tables.
    function automatic void modelStep(input int i);
        int lp[4];
        int rp[4];
        bit adv;
        bit anyReq;
        bit leftOn;
        bit rightOn;
        bit brakeShown;
        lp = '{0, 1, 3, 7};
        rp = '{0, 4, 6, 7};
        adv = 0;
        anyReq = left_req || right_req || hazard_req;
        if (mMd[i] == 0 && mPh[i] == 0 && !anyReq) begin
            mCnt[i] = 0;
        end else if (tick) begin
            mCnt[i] = mCnt[i] + 1;
            if (mCnt[i] == stepsOf[i]) begin
                mCnt[i] = 0;
                adv = 1;
            end
        end
        if (adv) begin
            if (mPh[i] == 0) begin
                if (hazard_req)                   mMd[i] = 3;
                else if (left_req && right_req)   mMd[i] = 3;
                else if (left_req)                mMd[i] = 1;
                else if (right_req)               mMd[i] = 2;
                else                              mMd[i] = 0;
                mHz[i] = hazard_req ? 1 : 0;
                mPh[i] = (mMd[i] != 0) ? 1 : 0;
            end else begin
                mPh[i] = (mPh[i] + 1) % 4;
            end
        end
        leftOn     = (mMd[i] == 1) || (mMd[i] == 3);
        rightOn    = (mMd[i] == 2) || (mMd[i] == 3);
        brakeShown = brake_req && !(mMd[i] == 3 && mHz[i] == 1);
        eLeft[i]  = leftOn  ? lp[mPh[i]] : (brakeShown ? 7 : 0);
        eRight[i] = rightOn ? rp[mPh[i]] : (brakeShown ? 7 : 0);
        eMode[i]  = mMd[i];
        eBusy[i]  = (mPh[i] != 0) ? 1 : 0;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 2; i++) begin
            mCnt[i] = 0; mPh[i] = 0; mMd[i] = 0; mHz[i] = 0;
            eLeft[i] = 0; eRight[i] = 0; eMode[i] = 0; eBusy[i] = 0;
        end
    endfunction

    // Model advances on the same edges as the DUT.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n)
            modelReset();
        else
            for (int i = 0; i < 2; i++) modelStep(i);
    end

    // Every-cycle compare, sampled 1 time unit after the rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        checkOutput("dut1_left",  int'(dut1Left),  eLeft[0]);
        checkOutput("dut1_right", int'(dut1Right), eRight[0]);
        checkOutput("dut1_mode",  int'(dut1Mode),  eMode[0]);
        checkOutput("dut1_busy",  int'(dut1Busy),  eBusy[0]);
        checkOutput("dut3_left",  int'(dut3Left),  eLeft[1]);
        checkOutput("dut3_right", int'(dut3Right), eRight[1]);
        checkOutput("dut3_mode",  int'(dut3Mode),  eMode[1]);
        checkOutput("dut3_busy",  int'(dut3Busy),  eBusy[1]);
        if (prevLeft == 0 && dut1Left == 3'b001) actCount++;
        prevLeft = int'(dut1Left);
    end

    task automatic doTick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_left",  int'(dut1Left),  0);
        checkOutput("rst_right", int'(dut1Right), 0);
        checkOutput("rst_mode",  int'(dut1Mode),  0);
        checkOutput("rst_busy",  int'(dut1Busy),  0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Left sweep, two full cycles
        $display("[TB] left sweep");
        actStart = actCount;
        left_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            doTick();
            checkOutput("left_seq",   int'(dut1Left),  leftSeq[i]);
            checkOutput("left_right", int'(dut1Right), 0);
        end
        checkOutput("left_activations", actCount - actStart, 2);

        // Reset mid-sweep
        $display("[TB] reset mid-sweep");
        doTick();
        doTick();
        checkOutput("pre_rst_left", int'(dut1Left), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_left",  int'(dut1Left),  0);
        checkOutput("async_rst_right", int'(dut1Right), 0);
        checkOutput("async_rst_mode",  int'(dut1Mode),  0);
        checkOutput("async_rst_busy",  int'(dut1Busy),  0);
        repeat (5) @(negedge clk);
        checkOutput("held_rst_left", int'(dut1Left), 0);
        checkOutput("held_rst_mode", int'(dut1Mode), 0);
        left_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Right request dropped after the 110 phase
        $display("[TB] right drop");
        right_req = 1'b1;
        doTick(); checkOutput("drop_r1", int'(dut1Right), 4);
        doTick(); checkOutput("drop_r2", int'(dut1Right), 6);
        right_req = 1'b0;
        doTick(); checkOutput("drop_r3", int'(dut1Right), 7);
        checkOutput("drop_mode3", int'(dut1Mode), 2);
        doTick(); checkOutput("drop_r0", int'(dut1Right), 0);
        checkOutput("drop_mode0", int'(dut1Mode), 2);
        checkOutput("drop_busy0", int'(dut1Busy), 0);
        doTick(); checkOutput("drop_idle_mode", int'(dut1Mode), 0);
        checkOutput("drop_idle_r", int'(dut1Right), 0);
        doTick(); checkOutput("drop_no_restart", int'(dut1Right), 0);

        // Hazard raised mid-left sweep
        $display("[TB] hazard preempt");
        left_req = 1'b1;
        doTick(); checkOutput("hz_l1", int'(dut1Left), 1);
        doTick(); checkOutput("hz_l2", int'(dut1Left), 3);
        hazard_req = 1'b1;
        doTick(); checkOutput("hz_l3", int'(dut1Left), 7);
        checkOutput("hz_l3_mode", int'(dut1Mode), 1);
        doTick(); checkOutput("hz_l0", int'(dut1Left), 0);
        checkOutput("hz_l0_mode", int'(dut1Mode), 1);
        for (int i = 0; i < 4; i++) begin
            doTick();
            checkOutput("hz_both_left",  int'(dut1Left),  bothL[i]);
            checkOutput("hz_both_right", int'(dut1Right), bothR[i]);
            checkOutput("hz_both_mode",  int'(dut1Mode),  3);
        end
        left_req = 1'b0;
        hazard_req = 1'b0;
        doTick(); checkOutput("hz_end_mode", int'(dut1Mode), 0);

        // Brake
        $display("[TB] brake");
        brake_req = 1'b1;
        @(negedge clk);
        checkOutput("brk_idle_l", int'(dut1Left),  7);
        checkOutput("brk_idle_r", int'(dut1Right), 7);
        left_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            doTick();
            checkOutput("brk_left_sweep", int'(dut1Left),  bothL[i]);
            checkOutput("brk_right_on",   int'(dut1Right), 7);
        end
        hazard_req = 1'b1;
        doTick();
        checkOutput("brk_hz_l1", int'(dut1Left),  1);
        checkOutput("brk_hz_r1", int'(dut1Right), 4);
        doTick();
        checkOutput("brk_hz_l2", int'(dut1Left),  3);
        checkOutput("brk_hz_r2", int'(dut1Right), 6);
        hazard_req = 1'b0;
        left_req = 1'b0;
        doTick();
        doTick();
        checkOutput("brk_hz_l0", int'(dut1Left),  0);
        checkOutput("brk_hz_r0", int'(dut1Right), 0);
        doTick();
        checkOutput("brk_back_idle_l", int'(dut1Left),  7);
        checkOutput("brk_back_idle_r", int'(dut1Right), 7);
        brake_req = 1'b0;
        @(negedge clk);
        checkOutput("brk_release_l", int'(dut1Left),  0);
        checkOutput("brk_release_r", int'(dut1Right), 0);

        // Divider, STEP_TICKS=3 instance
        $display("[TB] divider");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        left_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            doTick();
            checkOutput("div3_left", int'(dut3Left), div3Seq[i]);
        end
        left_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
